// File: rtl/reg_word_serializer.sv
// Parallel-to-serial word unloader: takes one WIDTH-bit word over valid/ready and
// returns it as WIDTH/CHUNK beats of CHUNK bits, with back-to-back words and no bubble.
module reg_word_serializer #(
    parameter int WIDTH     = 64,
    parameter int CHUNK     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CHUNK-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int BEATS = WIDTH / CHUNK;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_live;
    logic [CHUNK-1:0] w_chunk;
    logic [WIDTH-1:0] w_shifted;
    logic             w_last;

    // Emitting end of the shift register and the register advanced by one beat.
    assign w_chunk   = LSB_FIRST ? r_sreg[CHUNK-1:0] : r_sreg[WIDTH-1 -: CHUNK];
    assign w_shifted = LSB_FIRST ? (r_sreg >> CHUNK) : (r_sreg << CHUNK);
    assign w_last    = (r_cnt == LAST_CNT);

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (no latches).
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        busy        = 1'b0;

        case (r_state)
            S_IDLE: begin
                // r_live holds in_ready low while reset is asserted.
                in_ready = r_live;
                if (in_valid && r_live) begin
                    w_sreg_nxt  = in_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = w_chunk;
                out_last  = w_last;
                if (out_ready) begin
                    if (!w_last) begin
                        w_sreg_nxt = w_shifted;
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                    end else begin
                        // Last beat leaving: accept the next word in the same cycle.
                        in_ready  = 1'b1;
                        w_cnt_nxt = '0;
                        if (in_valid) begin
                            w_sreg_nxt = in_data;
                        end else begin
                            w_sreg_nxt  = '0;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all of it, sreg included, resets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_live  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_word_serializer.sv
// Directed bench for reg_word_serializer: 64/8 LSB-first table vectors plus
// hand-written reset, async-reset mid-word and 8/1 MSB-first sequences.
module tb_reg_word_serializer;

    logic        clk;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_data8;
    logic        out_valid8;
    logic        out_ready8;
    logic [0:0]  out_data8;
    logic        out_last8;
    logic        busy8;

    int n_vec;
    int n_fail;

    reg_word_serializer #(.WIDTH(64), .CHUNK(8), .LSB_FIRST(1'b1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    reg_word_serializer #(.WIDTH(8), .CHUNK(1), .LSB_FIRST(1'b0)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .out_last  (out_last8),
        .busy      (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [63:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] W1    = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WA    = 64'h1111_1111_1111_1111;
    localparam logic [63:0] WB    = 64'h2222_2222_2222_2222;
    localparam logic [63:0] WR    = 64'hFFEE_DDCC_BBAA_9988;
    localparam logic [63:0] JUNK  = 64'hDEAD_BEEF_DEAD_BEEF;

    logic [7:0] w1_bytes [8];
    logic [7:0] wr_bytes [4];
    logic [7:0] a5_bits;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic iv, input logic [63:0] id, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                                input logic e_ol, input logic e_busy);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol; v.e_busy = e_busy;
        vecs.push_back(v);
    endfunction

    task automatic check_idle8(input string name);
        check({name, ".in_ready"},  64'(in_ready),  64'(1'b1));
        check({name, ".out_valid"}, 64'(out_valid), 64'(1'b0));
        check({name, ".busy"},      64'(busy),      64'(1'b0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int beat;
        logic rdy;

        n_vec  = 0;
        n_fail = 0;
        w1_bytes = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        wr_bytes = '{8'h88, 8'h99, 8'hAA, 8'hBB};
        a5_bits  = 8'hA5;

        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        in_data8   = '0;
        out_ready8 = 1'b1;

        // ---------------- vector table ----------------
        // single word, out_ready=1
        add(1'b1, W1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++)
            add(1'b0, JUNK, 1'b1, b == 7, 1'b1, w1_bytes[b], b == 7, 1'b1);
        add(1'b0, JUNK, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        // backpressure, out_ready pattern 1,0,0,1,0,0,...; in_valid offered during stalls
        add(1'b1, W1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        beat = 0;
        for (int c = 0; c < 22; c++) begin
            rdy = (c % 3 == 0);
            add(!rdy, JUNK, rdy, (beat == 7) && rdy, 1'b1, w1_bytes[beat], beat == 7, 1'b1);
            if (rdy) beat++;
        end
        add(1'b0, JUNK, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        // back-to-back A then B with in_valid held
        add(1'b1, WA, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++)
            add(1'b1, WB, 1'b1, b == 7, 1'b1, 8'h11, b == 7, 1'b1);
        for (int b = 0; b < 8; b++)
            add(1'b0, JUNK, 1'b1, b == 7, 1'b1, 8'h22, b == 7, 1'b1);
        add(1'b0, JUNK, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // ---------------- power-on reset ----------------
        #2;
        check("por.in_ready",  64'(in_ready),  64'(1'b0));
        check("por.out_valid", 64'(out_valid), 64'(1'b0));
        check("por.out_data",  64'(out_data),  64'(8'h00));
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);

        // ---------------- table run ----------------
        foreach (vecs[i]) begin
            #1;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d.in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
            check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            check($sformatf("vec%0d.out_data", i),  64'(out_data),  64'(vecs[i].e_od));
            check($sformatf("vec%0d.out_last", i),  64'(out_last),  64'(vecs[i].e_ol));
            check($sformatf("vec%0d.busy", i),      64'(busy),      64'(vecs[i].e_busy));
            @(posedge clk);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // ---------------- mid-sim reset, then idle ----------------
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst%0d.in_ready", k),  64'(in_ready),  64'(1'b0));
            check($sformatf("rst%0d.out_valid", k), 64'(out_valid), 64'(1'b0));
            @(posedge clk);
        end
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle8("post_rst");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("idle%0d.out_valid", k), 64'(out_valid), 64'(1'b0));
        end

        // ---------------- async reset mid-word ----------------
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = WR;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = JUNK;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("arst_beat%0d", k), 64'(out_data), 64'(wr_bytes[k]));
            if (k < 3) @(posedge clk);
        end
        #2 reset = 1'b0;
        #1;
        check("arst.out_valid", 64'(out_valid), 64'(1'b0));
        check("arst.busy",      64'(busy),      64'(1'b0));
        check("arst.out_data",  64'(out_data),  64'(8'h00));
        check("arst.in_ready",  64'(in_ready),  64'(1'b0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle8("arst_rel");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("arst_left%0d", k), 64'(out_valid), 64'(1'b0));
        end

        // ---------------- MSB-first, WIDTH=8, CHUNK=1 ----------------
        @(posedge clk);
        #1;
        in_valid8 = 1'b1;
        in_data8  = 8'hA5;
        @(negedge clk);
        check("msb.in_ready", 64'(in_ready8), 64'(1'b1));
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_data8  = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("msb%0d.valid", k), 64'(out_valid8), 64'(1'b1));
            check($sformatf("msb%0d.bit", k),   64'(out_data8),  64'(a5_bits[7-k]));
            check($sformatf("msb%0d.last", k),  64'(out_last8),  64'(k == 7));
            @(posedge clk);
        end
        @(negedge clk);
        check("msb.done_valid", 64'(out_valid8), 64'(1'b0));
        check("msb.done_ready", 64'(in_ready8),  64'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_word_serializer.md
Name: reg_word_serializer

Overview:
- Reader/unload side of the enable-gated register storage: accepts one parallel WIDTH-bit word and returns it as WIDTH/CHUNK sequential chunks over a valid/ready stream.
- Used to read out register-file or snapshot contents through a narrow debug or trace path, e.g. 64-bit words as 8 bytes.
- Parallel input and serial output both use valid/ready handshakes.
- Supports back-to-back words with no bubble cycle.

Parameters:
- WIDTH, 64, width of the parallel word; must be an integer multiple of CHUNK.
- CHUNK, 8, bits emitted per output beat; 1 <= CHUNK <= WIDTH.
- LSB_FIRST, 1, 1 = beat 0 carries in_data[CHUNK-1:0]; 0 = beat 0 carries in_data[WIDTH-1:WIDTH-CHUNK].

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- in_valid  input  1  parallel word offered.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word; sampled only when in_valid && in_ready.
- out_valid  output  1  out_data holds a valid chunk.
- out_ready  input  1  consumer accepts the chunk this cycle.
- out_data  output  CHUNK  current chunk.
- out_last  output  1  current chunk is the final beat of the word.
- busy  output  1  a word is held and not yet fully emitted.

Behaviour:
- Storage:
  - WIDTH-bit shift register sreg.
  - Beat counter cnt, width $clog2(WIDTH/CHUNK), minimum 1 bit.
  - State: IDLE or SHIFT.
- Reset (reset==0, asynchronous):
  - state=IDLE, sreg=0, cnt=0.
  - Outputs: out_valid=0, out_last=0, out_data=0, busy=0.
  - in_ready goes 0 while reset is asserted and 1 on the first cycle after release.
  - A word in progress is discarded; no partial beats are emitted after reset.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: sreg<=in_data, cnt<=0, state<=SHIFT.
  - First beat is visible the next cycle, so load-to-first-beat latency is 1 clk.
- SHIFT:
  - out_valid=1, busy=1.
  - out_data = sreg[CHUNK-1:0] when LSB_FIRST, otherwise sreg[WIDTH-1:WIDTH-CHUNK].
  - out_last = (cnt == WIDTH/CHUNK-1).
- Output beat accepted (out_valid && out_ready), not last:
  - sreg shifts by CHUNK toward the emitting end; vacated bits fill with 0.
  - cnt<=cnt+1.
- Output beat accepted, last:
  - If in_valid: load the new word, cnt<=0, stay in SHIFT (back-to-back, no bubble).
  - Otherwise: state<=IDLE, cnt<=0.
- in_ready = IDLE || (SHIFT && out_last && out_ready).
  - This is combinational from out_ready; it is the only comb path input-to-output.
- Stall (out_valid && !out_ready):
  - out_data, out_last and sreg hold.
  - in_ready=0 and in_data is ignored.
- out_data must not change while out_valid=1 and the beat has not been accepted. This is an AXI-style stability rule.
- Word emission takes exactly WIDTH/CHUNK accepted beats. cnt never exceeds WIDTH/CHUNK-1 and wraps to 0 only on a new load.
- Degenerate CHUNK==WIDTH: every beat has out_last=1, giving one beat per word.
- in_valid may drop before acceptance with no effect. A word not accepted is never emitted.

Test Plan:
- Reset, then idle:
  - Drive reset=0 mid-sim for 3 clk and release.
  - Required: in_ready=1, out_valid=0, busy=0. No beat appears with in_valid=0 for 10 clk.
- Single word, LSB_FIRST=1, out_ready=1:
  - Load 64'h0123456789ABCDEF.
  - Required: 8 consecutive beats EF,CD,AB,89,67,45,23,01; out_last on beat 8 only; first beat 1 clk after load; then IDLE.
- Backpressure:
  - Same word, out_ready toggles 1,0,0,1,...
  - Required: out_data holds during 0 cycles, byte order is unchanged, in_ready=0 throughout.
- Back-to-back:
  - in_valid held with words A=64'h1111...11 and B=64'h2222...22.
  - Required: B is accepted on A's last beat; 16 beats on 16 consecutive clk; out_valid never drops.
- Async reset mid-word:
  - Assert reset after beat 3 of 64'hFFEEDDCCBBAA9988, between clock edges.
  - Required: out_valid=0 immediately. After release, in_ready=1 and no leftover beats.
- MSB_FIRST with CHUNK=1, WIDTH=8:
  - Load 8'hA5.
  - Required: bits 1,0,1,0,0,1,0,1 over 8 beats, with out_last on the 8th.
